score_ctrl: RTL and testbench
=============================

Name: score_ctrl

Overview:
Game-level controller for the 3-digit decimal score datapath.
- Sequences a game through idle, play, compare and show phases.
- Counts score events as BCD and keeps the session high score.
- Selects which 3-digit value drives the hex displays.
- Sits between the snake game FSM (eat/start/game_over) and the HEX decoders.

Parameters:
POINTS_PER_EAT, 1, BCD points added per eat event; legal 1..9.
ALT_CYCLES, 25000000, clocks per display phase in SHOW (current score vs high score); must be >=2.

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous and active-high
start  input  1  pulse; begin a new game
eat  input  1  level from game logic; each rising edge is one score event
game_over  input  1  pulse; end current game
clear_hs  input  1  pulse; zero the high score
score_bcd  output  12  current score, {hundreds,tens,ones}, 4 bits each
high_bcd  output  12  high score, same packing
disp_bcd  output  12  value routed to HEX3..HEX1
new_record  output  1  last game beat the high score
playing  output  1  high in PLAY
state_o  output  3  FSM state code for debug

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. score_bcd=0, high_bcd=0, new_record=0, playing=0, disp_bcd=0, alt counter=0, eat_q=0.
- Reset mid-game has the same effect: the high score is lost.
- State codes: IDLE=0, PLAY=1, COMPARE=2, UPDATE=3, SHOW=4.
- Edge detect:
  - eat_q registers eat every cycle, in all states.
  - An event is eat & ~eat_q; it is acted on only in PLAY.
  - score_bcd is updated on the edge after the cycle where eat rises (1-cycle latency).
  - A level held high counts once.
- BCD add: ones += POINTS_PER_EAT, with decimal carry into tens and then hundreds.
  - Saturates at 999: any add that would exceed 999 yields 999, and digits never exceed 9.
- IDLE:
  - disp_bcd=high_bcd.
  - start -> PLAY, with score_bcd cleared and new_record cleared.
  - clear_hs -> high_bcd=0.
- PLAY:
  - playing=1, disp_bcd=score_bcd.
  - game_over -> COMPARE.
  - start and clear_hs are ignored.
  - An eat event in the same cycle as game_over is counted.
- COMPARE (1 cycle):
  - Compares the registered score_bcd, which already includes any simultaneous eat, against high_bcd, as an unsigned 12-bit BCD compare.
  - If strictly greater -> UPDATE; else -> SHOW.
- UPDATE (1 cycle): high_bcd<=score_bcd, new_record<=1 -> SHOW.
- SHOW:
  - The alt counter runs 0..ALT_CYCLES-1.
  - disp_bcd=score_bcd in the first phase and high_bcd in the second phase, with the phase toggling at each counter wrap.
  - The counter and phase reset to 0 on entry to SHOW.
  - start -> PLAY, clearing score and new_record.
  - clear_hs -> high_bcd=0; new_record is unchanged.
- start and clear_hs asserted together in IDLE/SHOW: the clear applies, then PLAY is entered.
- Tie score == high: no update, new_record=0.
- game_over outside PLAY is ignored.
- disp_bcd is registered and follows the state/phase with 1-cycle latency.

Optional Feature:
SCORE_CTRL_FLASH_EN:
- Defined: in SHOW with new_record=1, new_record output toggles at each alt-counter wrap (blink source for LEDs). The internal flag stays set, and the toggle starts at 1 on entry to SHOW.
- Undefined: new_record is a steady level.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset, start, 12 eat rising edges (POINTS_PER_EAT=1) -> score_bcd=12'h012, playing=1, disp_bcd=12'h012. eat held high 50 cycles adds exactly 1.
2. Score 12'h012, game_over, high=0 -> COMPARE, UPDATE, SHOW. high_bcd=12'h012, new_record=1. disp alternates 012/012 every ALT_CYCLES (use ALT_CYCLES=4).
3. Second game: start, score 7, game_over -> high stays 12'h012, new_record=0. SHOW alternates 007/012 each 4 cycles.
4. Saturation: POINTS_PER_EAT=9, 112 events -> score_bcd=12'h999 and stays at 999 on further events. Check the 099->108 and 999-clamp carries.
5. Simultaneous: score 12'h012 = high, eat edge and game_over in the same cycle -> score 013, high_bcd=12'h013, new_record=1. Separately, rst asserted in PLAY -> all outputs 0, state_o=0 next cycle.
6. clear_hs in PLAY is ignored. clear_hs+start together in SHOW -> high_bcd=0, state_o=1, score_bcd=0. With SCORE_CTRL_FLASH_EN defined, new_record toggles every ALT_CYCLES in SHOW after a record.

Source files
------------

// File: rtl/score_ctrl.sv
// Game-level controller for the 3-digit BCD score: sequencing, high score, display select.
// Optional build macro SCORE_CTRL_FLASH_EN: new_record blinks in SHOW after a record.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset; display shows high score, waits for start
// PLAY    | game running; eat rising edges add points
// COMPARE | one cycle; final score vs high score
// UPDATE  | one cycle; latch new high score, flag record
// SHOW    | alternate score / high score on display until next start
module score_ctrl #(
    parameter int POINTS_PER_EAT = 1,
    parameter int ALT_CYCLES     = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        eat,
    input  logic        game_over,
    input  logic        clear_hs,
    output logic [11:0] score_bcd,
    output logic [11:0] high_bcd,
    output logic [11:0] disp_bcd,
    output logic        new_record,
    output logic        playing,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_COMPARE = 3'd2,
        S_UPDATE  = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    localparam int             CNT_W    = $clog2(ALT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALT_CYCLES - 1);
    localparam logic [3:0]     PTS      = 4'(POINTS_PER_EAT);

    state_t            state_q, state_d;
    logic [11:0]       score_q, score_d;
    logic [11:0]       high_q, high_d;
    logic [11:0]       disp_q, disp_d;
    logic              rec_q, rec_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic              eat_q;
    logic              eat_rise;

    // Digit-wise add with decimal carry; a carry out of hundreds clamps to 999.
    function automatic logic [11:0] bcd_add_sat(input logic [11:0] v);
        logic [4:0]  ones;
        logic [4:0]  tens;
        logic [4:0]  hund;
        logic [11:0] r;
        ones = {1'b0, v[3:0]} + {1'b0, PTS};
        tens = {1'b0, v[7:4]};
        hund = {1'b0, v[11:8]};
        if (ones > 5'd9) begin
            ones = ones - 5'd10;
            tens = tens + 5'd1;
        end
        if (tens > 5'd9) begin
            tens = tens - 5'd10;
            hund = hund + 5'd1;
        end
        if (hund > 5'd9) r = 12'h999;
        else             r = {hund[3:0], tens[3:0], ones[3:0]};
        return r;
    endfunction

    assign eat_rise = eat & ~eat_q;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        high_d  = high_q;
        rec_d   = rec_q;
        cnt_d   = '0;
        phase_d = 1'b0;
        disp_d  = score_q;
        case (state_q)
            S_IDLE: begin
                disp_d = high_q;
                if (clear_hs) high_d = '0;
                if (start) begin
                    state_d = S_PLAY;
                    score_d = '0;
                    rec_d   = 1'b0;
                end
            end
            S_PLAY: begin
                disp_d = score_q;
                if (eat_rise)  score_d = bcd_add_sat(score_q);
                if (game_over) state_d = S_COMPARE;
            end
            // Packed BCD orders the same as binary, so a plain compare suffices.
            S_COMPARE: begin
                state_d = (score_q > high_q) ? S_UPDATE : S_SHOW;
            end
            S_UPDATE: begin
                high_d  = score_q;
                rec_d   = 1'b1;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                disp_d = phase_q ? high_q : score_q;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    phase_d = phase_q;
                end
                if (clear_hs) high_d = '0;
                if (start) begin
                    state_d = S_PLAY;
                    score_d = '0;
                    rec_d   = 1'b0;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            score_q <= '0;
            high_q  <= '0;
            disp_q  <= '0;
            rec_q   <= 1'b0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            eat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            high_q  <= high_d;
            disp_q  <= disp_d;
            rec_q   <= rec_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            eat_q   <= eat;
        end
    end

    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign disp_bcd  = disp_q;
    assign playing   = (state_q == S_PLAY);
    assign state_o   = state_q;

`ifdef SCORE_CTRL_FLASH_EN
    // Blink follows the inverse of the display phase: on for the first phase of SHOW.
    assign new_record = rec_q & ~((state_q == S_SHOW) & phase_q);
`else
    assign new_record = rec_q;
`endif

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: two instances (1 and 9 points per eat) checked every cycle
// against a decimal-integer game model, plus hand-computed literal checkpoints.
module tb_score_ctrl;

    localparam int ALT = 4;
`ifdef SCORE_CTRL_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    typedef struct packed {
        int st;
        int score;
        int high;
        int disp;
        int show_t;
        bit rec;
        bit eat_prev;
    } model_t;

    logic        clk, rst, start, eat, game_over, clear_hs;
    logic [11:0] score_o [2];
    logic [11:0] high_o  [2];
    logic [11:0] disp_o  [2];
    logic        rec_o   [2];
    logic        play_o  [2];
    logic [2:0]  st_o    [2];

    model_t mdl [2];
    int     checks = 0;
    int     errors = 0;
    bit     cmp_en = 1'b0;

    score_ctrl #(.POINTS_PER_EAT(1), .ALT_CYCLES(ALT)) dut1 (
        .clk(clk), .rst(rst), .start(start), .eat(eat), .game_over(game_over),
        .clear_hs(clear_hs), .score_bcd(score_o[0]), .high_bcd(high_o[0]),
        .disp_bcd(disp_o[0]), .new_record(rec_o[0]), .playing(play_o[0]), .state_o(st_o[0])
    );

    score_ctrl #(.POINTS_PER_EAT(9), .ALT_CYCLES(ALT)) dut9 (
        .clk(clk), .rst(rst), .start(start), .eat(eat), .game_over(game_over),
        .clear_hs(clear_hs), .score_bcd(score_o[1]), .high_bcd(high_o[1]),
        .disp_bcd(disp_o[1]), .new_record(rec_o[1]), .playing(play_o[1]), .state_o(st_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int n);
        logic [11:0] b;
        b[11:8] = 4'((n / 100) % 10);
        b[7:4]  = 4'((n / 10) % 10);
        b[3:0]  = 4'(n % 10);
        return b;
    endfunction

    // Game rules in decimal: state codes 0 idle, 1 play, 2 compare, 3 update, 4 show.
    function automatic model_t step(input model_t m, input int p, input bit r, input bit s,
                                    input bit e, input bit g, input bit c);
        model_t n;
        bit     ev;
        n = m;
        if (r) begin
            n = '0;
            return n;
        end
        ev = e && !m.eat_prev;
        n.eat_prev = e;
        if (m.st == 0)      n.disp = m.high;
        else if (m.st == 4) n.disp = (((m.show_t / ALT) % 2) == 0) ? m.score : m.high;
        else                n.disp = m.score;
        case (m.st)
            0: begin
                if (c) n.high = 0;
                if (s) begin n.st = 1; n.score = 0; n.rec = 1'b0; end
            end
            1: begin
                if (ev) n.score = (m.score + p > 999) ? 999 : m.score + p;
                if (g)  n.st = 2;
            end
            2: begin
                n.st = (m.score > m.high) ? 3 : 4;
                n.show_t = 0;
            end
            3: begin
                n.high = m.score; n.rec = 1'b1; n.st = 4; n.show_t = 0;
            end
            default: begin
                n.show_t = m.show_t + 1;
                if (c) n.high = 0;
                if (s) begin n.st = 1; n.score = 0; n.rec = 1'b0; end
            end
        endcase
        return n;
    endfunction

    function automatic bit exp_rec(input model_t m);
        bit r;
        r = m.rec;
        if (FLASH && m.st == 4 && ((m.show_t / ALT) % 2) == 1) r = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [11:0] act,
                       input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, idx, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        mdl[0] <= step(mdl[0], 1, rst, start, eat, game_over, clear_hs);
        mdl[1] <= step(mdl[1], 9, rst, start, eat, game_over, clear_hs);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("score", i, score_o[i], to_bcd(mdl[i].score));
                chk("high", i, high_o[i], to_bcd(mdl[i].high));
                chk("disp", i, disp_o[i], to_bcd(mdl[i].disp));
                chk("new_record", i, {11'd0, rec_o[i]}, {11'd0, exp_rec(mdl[i])});
                chk("playing", i, {11'd0, play_o[i]}, {11'd0, mdl[i].st == 1});
                chk("state", i, {9'd0, st_o[i]}, 12'(mdl[i].st));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic eat_edges(input int n);
        repeat (n) begin
            eat = 1'b1; tick(1);
            eat = 1'b0; tick(1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic pulse_over();
        game_over = 1'b1; tick(1); game_over = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; eat = 1'b0; game_over = 1'b0; clear_hs = 1'b0;
        tick(2);
        rst = 1'b0;
        cmp_en = 1'b1;
        tick(1);
        chk("lit_reset_score", 0, score_o[0], 12'h000);
        chk("lit_reset_state", 0, {9'd0, st_o[0]}, 12'h000);
        chk("lit_reset_disp", 0, disp_o[0], 12'h000);

        // Held level counts once, then 11 clean edges.
        pulse_start();
        eat = 1'b1; tick(50); eat = 1'b0; tick(1);
        chk("lit_hold_once", 0, score_o[0], 12'h001);
        eat_edges(11);
        chk("lit_score12", 0, score_o[0], 12'h012);
        chk("lit_disp12", 0, disp_o[0], 12'h012);
        chk("lit_playing", 0, {11'd0, play_o[0]}, 12'h001);
        chk("lit_carry_099_108", 1, score_o[1], 12'h108);

        // First game ends with a record.
        pulse_over(); tick(2);
        chk("lit_g1_state", 0, {9'd0, st_o[0]}, 12'h004);
        chk("lit_g1_high", 0, high_o[0], 12'h012);
        chk("lit_g1_rec", 0, {11'd0, rec_o[0]}, 12'h001);
        chk("lit_g1_high9", 1, high_o[1], 12'h108);
        tick(10);

        // Second game below the high score.
        pulse_start();
        eat_edges(7);
        pulse_over(); tick(1);
        chk("lit_g2_state", 0, {9'd0, st_o[0]}, 12'h004);
        chk("lit_g2_high", 0, high_o[0], 12'h012);
        chk("lit_g2_rec", 0, {11'd0, rec_o[0]}, 12'h000);
        chk("lit_g2_score9", 1, score_o[1], 12'h063);
        tick(10);

        // Saturation.
        pulse_start();
        eat_edges(112);
        chk("lit_sat999", 1, score_o[1], 12'h999);
        chk("lit_sat_p1", 0, score_o[0], 12'h112);
        eat_edges(3);
        chk("lit_sat_hold", 1, score_o[1], 12'h999);
        chk("lit_p1_115", 0, score_o[0], 12'h115);

        // Reset mid-game.
        rst = 1'b1; tick(1);
        chk("lit_rst_state", 0, {9'd0, st_o[0]}, 12'h000);
        chk("lit_rst_high", 0, high_o[0], 12'h000);
        chk("lit_rst_score9", 1, score_o[1], 12'h000);
        rst = 1'b0;
        pulse_over(); tick(1);
        chk("lit_over_idle", 0, {9'd0, st_o[0]}, 12'h000);

        pulse_start(); eat_edges(12); pulse_over(); tick(2);
        pulse_start(); eat_edges(12);
        // Eat edge and game_over together at a tie: the eat breaks the tie.
        eat = 1'b1; game_over = 1'b1; tick(1);
        eat = 1'b0; game_over = 1'b0; tick(2);
        chk("lit_sim_score", 0, score_o[0], 12'h013);
        chk("lit_sim_high", 0, high_o[0], 12'h013);
        chk("lit_sim_rec", 0, {11'd0, rec_o[0]}, 12'h001);
        chk("lit_sim_high9", 1, high_o[1], 12'h117);
        tick(4);
        chk("lit_rec_phase1", 0, {11'd0, rec_o[0]}, FLASH ? 12'h000 : 12'h001);
        tick(4);
        chk("lit_rec_phase2", 0, {11'd0, rec_o[0]}, 12'h001);
        tick(6);

        // Tie with the high score: no record.
        pulse_start(); eat_edges(13); pulse_over(); tick(1);
        chk("lit_tie_rec", 0, {11'd0, rec_o[0]}, 12'h000);
        chk("lit_tie_state", 0, {9'd0, st_o[0]}, 12'h004);
        chk("lit_tie_high9", 1, high_o[1], 12'h117);

        // clear_hs ignored in PLAY; clear+start together in SHOW.
        pulse_start();
        clear_hs = 1'b1; tick(1); clear_hs = 1'b0;
        chk("lit_clr_play", 0, high_o[0], 12'h013);
        pulse_over(); tick(1);
        clear_hs = 1'b1; start = 1'b1; tick(1);
        clear_hs = 1'b0; start = 1'b0;
        chk("lit_clr_start_high", 0, high_o[0], 12'h000);
        chk("lit_clr_start_state", 0, {9'd0, st_o[0]}, 12'h001);
        chk("lit_clr_start_score", 0, score_o[0], 12'h000);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
